fir_lite_master: RTL and testbench

- AXI-Lite initiator that programs and launches the FIR accelerator over its AXI-Lite slave port (no B channel).
- On a start pulse it writes Tape_Num coefficients, writes data_length, sets ap_start, then polls ap_ctrl until ap_done.
- Sits beside the host or test sequencer. The FIR stream ports are driven separately.

---
 rtl/fir_pkg.sv | 34 +++
 rtl/fir_lite_master_if.sv | 29 ++
 rtl/axil_master_xact.sv | 125 ++++++++++++
 rtl/fir_lite_master.sv | 191 +++++++++++++++++++
 tb/tb_fir_lite_master.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR AXI-Lite programming master: register map,
// ap_ctrl bit positions and the sequencer state encoding.
// The ST_RB state exists only when TAP_READBACK_EN is defined.
package fir_pkg;

    localparam int ADDR_AP_CTRL  = 'h00;
    localparam int ADDR_DATA_LEN = 'h10;
    localparam int ADDR_TAP_BASE = 'h80;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    // ST_RB and ST_POLL each cover an AR phase followed by an R phase; the
    // transaction engine sequences the two phases.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_TAP,
`ifdef TAP_READBACK_EN
        ST_RB,
`endif
        ST_WR_LEN,
        ST_WR_START,
        ST_GAP,
        ST_POLL,
        ST_FIN
    } fir_state_e;

    // Byte address of coefficient register idx.
    function automatic int tap_offset(input logic [3:0] idx);
        return ADDR_TAP_BASE + 4 * int'(idx);
    endfunction

endpackage

// File: rtl/fir_lite_master_if.sv
// AXI-Lite signal bundle (AW, W, AR, R; no B channel) between the FIR
// programming master and the accelerator's slave port.
interface fir_lite_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        input  awready, wready, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
        output awready, wready, arready, rvalid, rdata
    );
endinterface

// File: rtl/axil_master_xact.sv
// Single AXI-Lite transaction engine. A req seen while idle launches one
// write (AW+W) or one read (AR then R); ack pulses one cycle after the
// transaction finishes, with rdata holding the captured read data.
//
// Handshake rule: a channel transfers on a rising clock edge where its valid
// and ready are both high; a valid, once raised, stays high with stable
// payload until that edge and drops in the following cycle. Only reset
// removes a valid early.
module axil_master_xact
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   req,
    input  logic                   is_write,
    input  logic [pADDR_WIDTH-1:0] addr,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   ack,
    output logic [pDATA_WIDTH-1:0] rdata,
    fir_lite_master_if.master      axil
);

    logic                   active_q,  active_d;
    logic                   wr_q,      wr_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q,  wvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q,  rready_d;
    logic                   ack_q,     ack_d;
    logic [pADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [pDATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [pDATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                   aw_hs, w_hs;

    // Launch, per-channel handshake tracking and completion detection.
    always_comb begin
        active_d  = active_q;
        wr_d      = wr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_hs     = awvalid_q & axil.awready;
        w_hs      = wvalid_q & axil.wready;
        if (!active_q) begin
            if (req) begin
                active_d = 1'b1;
                wr_d     = is_write;
                addr_d   = addr;
                wdata_d  = wdata;
                if (is_write) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
        end else if (wr_q) begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            // A channel is finished once its valid is low again or it
            // handshakes now; the write completes when both are finished.
            if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                active_d = 1'b0;
                ack_d    = 1'b1;
            end
        end else begin
            if (arvalid_q && axil.arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            if (rready_q && axil.rvalid) begin
                rready_d = 1'b0;
                rdata_d  = axil.rdata;
                active_d = 1'b0;
                ack_d    = 1'b1;
            end
        end
    end

    // Transaction state registers; reset drops every valid at once.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            active_q  <= 1'b0;
            wr_q      <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            active_q  <= active_d;
            wr_q      <= wr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign axil.awvalid = awvalid_q;
    assign axil.awaddr  = addr_q;
    assign axil.wvalid  = wvalid_q;
    assign axil.wdata   = wdata_q;
    assign axil.arvalid = arvalid_q;
    assign axil.araddr  = addr_q;
    assign axil.rready  = rready_q;
    assign ack          = ack_q;
    assign rdata        = rdata_q;

endmodule

// File: rtl/fir_lite_master.sv
// FIR accelerator programming master: on start it writes Tape_Num taps,
// data_length and ap_start over AXI-Lite, then polls ap_ctrl until ap_done
// or until pPOLL_MAX status reads have been made (timeout sets err).
// Optional build macro TAP_READBACK_EN: read back every tap after writing
// and flag any mismatch on err (the sequence continues regardless).
module fir_lite_master
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int pPOLL_GAP   = 4,
    parameter int pPOLL_MAX   = 1023
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   start,
    input  logic [pDATA_WIDTH-1:0] data_len,
    output logic [3:0]             coef_idx,
    input  logic [pDATA_WIDTH-1:0] coef_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output fir_state_e             state_dbg,
    fir_lite_master_if.master      axil
);

    localparam logic [3:0]  LAST_TAP = 4'(Tape_Num - 1);
    localparam logic [15:0] GAP_LAST = (pPOLL_GAP == 0) ? 16'd0 : 16'(pPOLL_GAP - 1);
    localparam logic [9:0]  POLL_MAX = 10'(pPOLL_MAX);
    localparam fir_state_e  ST_AFTER_START = (pPOLL_GAP == 0) ? ST_POLL : ST_GAP;

    fir_state_e             state_q, state_d;
    logic [3:0]             idx_q,   idx_d;
    logic [pDATA_WIDTH-1:0] len_q,   len_d;
    logic                   err_q,   err_d;
    logic [9:0]             poll_q,  poll_d;
    logic [15:0]            gap_q,   gap_d;
    logic [9:0]             poll_sat;

    logic                   x_req, x_write, x_ack;
    logic [pADDR_WIDTH-1:0] x_addr;
    logic [pDATA_WIDTH-1:0] x_wdata, x_rdata;
    logic                   unused_rdata;

    axil_master_xact #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .pDATA_WIDTH (pDATA_WIDTH)
    ) u_xact (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .req        (x_req),
        .is_write   (x_write),
        .addr       (x_addr),
        .wdata      (x_wdata),
        .ack        (x_ack),
        .rdata      (x_rdata),
        .axil       (axil)
    );

    // Sequencer next state and transaction requests. req is withheld in the
    // ack cycle so a finished transaction is never issued a second time.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        err_d    = err_q;
        poll_d   = poll_q;
        gap_d    = gap_q;
        x_req    = 1'b0;
        x_write  = 1'b1;
        x_addr   = '0;
        x_wdata  = '0;
        poll_sat = (poll_q == 10'h3FF) ? poll_q : poll_q + 10'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR_TAP;
                    idx_d   = '0;
                    len_d   = data_len;
                    err_d   = 1'b0;
                    poll_d  = '0;
                end
            end
            ST_WR_TAP: begin
                x_req   = !x_ack;
                x_addr  = pADDR_WIDTH'(tap_offset(idx_q));
                x_wdata = coef_data;
                if (x_ack) begin
                    if (idx_q == LAST_TAP) begin
                        idx_d = '0;
`ifdef TAP_READBACK_EN
                        state_d = ST_RB;
`else
                        state_d = ST_WR_LEN;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`ifdef TAP_READBACK_EN
            ST_RB: begin
                x_req   = !x_ack;
                x_write = 1'b0;
                x_addr  = pADDR_WIDTH'(tap_offset(idx_q));
                if (x_ack) begin
                    if (x_rdata != coef_data) err_d = 1'b1;
                    if (idx_q == LAST_TAP) begin
                        idx_d   = '0;
                        state_d = ST_WR_LEN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
`endif
            ST_WR_LEN: begin
                x_req   = !x_ack;
                x_addr  = pADDR_WIDTH'(ADDR_DATA_LEN);
                x_wdata = len_q;
                if (x_ack) state_d = ST_WR_START;
            end
            ST_WR_START: begin
                x_req   = !x_ack;
                x_addr  = pADDR_WIDTH'(ADDR_AP_CTRL);
                x_wdata = pDATA_WIDTH'(1) << AP_START_BIT;
                if (x_ack) begin
                    state_d = ST_AFTER_START;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_POLL;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ST_POLL: begin
                x_req   = !x_ack;
                x_write = 1'b0;
                x_addr  = pADDR_WIDTH'(ADDR_AP_CTRL);
                if (x_ack) begin
                    if (x_rdata[AP_DONE_BIT]) begin
                        state_d = ST_FIN;
                    end else begin
                        poll_d = poll_sat;
                        gap_d  = '0;
                        if (poll_sat >= POLL_MAX) begin
                            err_d   = 1'b1;
                            state_d = ST_FIN;
                        end else begin
                            state_d = ST_AFTER_START;
                        end
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            poll_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            err_q   <= err_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
        end
    end

    assign coef_idx     = idx_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign done         = (state_q == ST_FIN);
    assign err          = err_q;
    assign state_dbg    = state_q;
    // Only ap_done matters in the default build; the other bits are unused.
    assign unused_rdata = ^x_rdata;

endmodule

// File: tb/tb_fir_lite_master.sv
// Bench for fir_lite_master: AXI-Lite slave model with programmable AW
// ready delay, ap_done schedule and tap readback corruption; expected writes
// and read addresses are queued at launch and popped as the DUT transfers.
module tb_fir_lite_master;
    import fir_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int NTAP  = 11;
    localparam int PGAP  = 4;
    localparam int PMAX  = 8;
`ifdef TAP_READBACK_EN
    localparam int RB_N  = NTAP;
`else
    localparam int RB_N  = 0;
`endif

    // ---------------- clock / reset ----------------
    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          start;
    logic [DW-1:0] data_len;
    logic [3:0]    coef_idx;
    logic [DW-1:0] coef_data;
    logic          busy, done, err;
    fir_state_e    state_dbg;

    always #5 axis_clk = ~axis_clk;

    fir_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) axil ();

    fir_lite_master #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .Tape_Num    (NTAP),
        .pPOLL_GAP   (PGAP),
        .pPOLL_MAX   (PMAX)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .start      (start),
        .data_len   (data_len),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .state_dbg  (state_dbg),
        .axil       (axil)
    );

    logic [DW-1:0] coef_mem [16];
    assign coef_data = coef_mem[coef_idx];

    // ---------------- scoreboard state ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    rd_exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int wr_count, rd_count, poll_seen, done_after, aw_hold, idle_cyc;
    bit corrupt, last_was_poll;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model / monitor ----------------
    logic [DW-1:0] tap_mem [16];
    bit got_aw, got_w;
    logic [AW-1:0] cap_addr, rd_addr;
    logic [DW-1:0] cap_data;
    int aw_cyc, w_cyc, aw_run;
    bit aw_hs, w_hs, ar_hs, r_hs;

    initial begin
        axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
        axil.rvalid  = 1'b0; axil.rdata  = '0;
    end

    always @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            got_aw = 0; got_w = 0; aw_cyc = 0; w_cyc = 0; aw_run = 0;
            axil.awready = 1'b0; axil.wready = 1'b0; axil.arready = 1'b0;
            axil.rvalid  = 1'b0; axil.rdata  = '0;
        end else begin
            aw_hs = axil.awvalid && axil.awready;
            w_hs  = axil.wvalid && axil.wready;
            ar_hs = axil.arvalid && axil.arready;
            r_hs  = axil.rvalid && axil.rready;
            if (axil.awvalid) aw_cyc++;
            if (axil.wvalid)  w_cyc++;
            if (!axil.arvalid && !axil.rready && !axil.rvalid) idle_cyc++;
            if (aw_hs) begin got_aw = 1; cap_addr = axil.awaddr; end
            if (w_hs)  begin got_w = 1;  cap_data = axil.wdata;  end
            if (got_aw && got_w) begin
                wr_count++;
                check("wr_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("wr_addr_data", {cap_addr, cap_data}, exp_q.pop_front());
                check("aw_valid_cycles", aw_cyc, aw_hold);
                check("w_valid_cycles", w_cyc, 1);
                if (cap_addr >= 12'h080) tap_mem[(cap_addr - 12'h080) >> 2] = cap_data;
                got_aw = 0; got_w = 0; aw_cyc = 0; w_cyc = 0;
            end
            if (ar_hs) begin
                rd_count++;
                rd_addr = axil.araddr;
                check("rd_pending", rd_exp_q.size() != 0, 1);
                if (rd_exp_q.size() != 0) check("rd_addr", rd_addr, rd_exp_q.pop_front());
                if (rd_addr == 12'h000 && last_was_poll) check("poll_gap_min", idle_cyc >= PGAP, 1);
            end
            if (r_hs) begin
                last_was_poll = (rd_addr == 12'h000);
                idle_cyc = 0;
            end
            #1;
            if (axil.awvalid) begin
                axil.awready = (aw_run >= aw_hold - 1);
                aw_run++;
            end else begin
                axil.awready = 1'b0;
                aw_run = 0;
            end
            axil.wready  = axil.wvalid;
            axil.arready = axil.arvalid;
            if (ar_hs) begin
                axil.rvalid = 1'b1;
                if (rd_addr == 12'h000) begin
                    poll_seen++;
                    axil.rdata = (poll_seen > done_after) ? 32'h6 : 32'h0;
                end else begin
                    axil.rdata = tap_mem[(rd_addr - 12'h080) >> 2] ^
                                 ((corrupt && rd_addr == 12'h094) ? 32'h0000_0100 : 32'h0);
                end
            end else if (r_hs) begin
                axil.rvalid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_seq(input logic [DW-1:0] len);
        for (int i = 0; i < NTAP; i++) exp_q.push_back({12'(12'h080 + 4 * i), coef_mem[i]});
        exp_q.push_back({12'h010, len});
        exp_q.push_back({12'h000, 32'h1});
    endtask

    task automatic push_reads(input int npolls);
        for (int i = 0; i < RB_N; i++) rd_exp_q.push_back(12'(12'h080 + 4 * i));
        for (int i = 0; i < npolls; i++) rd_exp_q.push_back(12'h000);
    endtask

    task automatic pulse_start(input logic [DW-1:0] len);
        @(negedge axis_clk); data_len = len; start = 1'b1;
        @(negedge axis_clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        bit seen = 0;
        bit prev_busy = busy;
        while (!seen && n < 3000) begin
            @(negedge axis_clk); n++;
            if (done) begin
                seen = 1;
                check({tag, "_busy_at_done"}, busy, 0);
                check({tag, "_busy_before_done"}, prev_busy, 1);
            end
            prev_busy = busy;
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge axis_clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    task automatic run_seq(input string tag, input logic [DW-1:0] len, input int npolls,
                           input int dafter, input logic exp_err, input bit poke);
        wr_count = 0; rd_count = 0; poll_seen = 0; done_after = dafter; last_was_poll = 0;
        push_seq(len);
        push_reads(npolls);
        pulse_start(len);
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_err_cleared"}, err, 0);
        if (poke) begin
            repeat (5) @(negedge axis_clk);
            pulse_start(32'd77);
        end
        wait_done(tag);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_writes"}, wr_count, NTAP + 2);
        check({tag, "_reads"}, rd_count, RB_N + npolls);
        check({tag, "_wr_q_empty"}, exp_q.size(), 0);
        check({tag, "_rd_q_empty"}, rd_exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        axis_rst_n = 1'b1; start = 1'b0; data_len = '0;
        aw_hold = 1; corrupt = 0; idle_cyc = 0; done_after = 0;
        for (int i = 0; i < 16; i++) begin coef_mem[i] = 32'(i + 1); tap_mem[i] = '0; end
        #3 axis_rst_n = 1'b0;
        #20;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.rready}, 0);
        check("rst_addr_data", {axil.awaddr, axil.araddr, axil.wdata}, 0);
        check("rst_coef_idx", coef_idx, 0);
        @(negedge axis_clk); axis_rst_n = 1'b1;
        repeat (2) @(negedge axis_clk);

        // Always-ready slave, taps 1..11, length 600, ap_done on 6th poll;
        // a start while busy is ignored.
        run_seq("basic", 32'd600, 6, 5, 1'b0, 1'b1);

        // AW ready delayed, W immediate; random taps and length.
        aw_hold = 3;
        for (int i = 0; i < NTAP; i++) coef_mem[i] = $urandom;
        run_seq("aw_delay", 32'($urandom_range(1, 4096)), 2, 1, 1'b0, 1'b0);
        aw_hold = 1;

        // ap_done never set: PMAX polls then err.
        run_seq("timeout", 32'd123, PMAX, 100000, 1'b1, 1'b0);
        // Following start clears err.
        run_seq("after_timeout", 32'd45, 3, 2, 1'b0, 1'b0);

        // Reset while a write address is outstanding.
        wr_count = 0; done_after = 0; poll_seen = 0;
        push_seq(32'd9);
        pulse_start(32'd9);
        n = 0;
        while (!(wr_count >= 3 && axil.awvalid) && n < 500) begin
            @(negedge axis_clk); n++;
        end
        check("mid_awvalid_seen", axil.awvalid, 1);
        #2 axis_rst_n = 1'b0;
        #1;
        check("async_rst_valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.rready}, 0);
        check("async_rst_busy", busy, 0);
        exp_q.delete();
        rd_exp_q.delete();
        @(negedge axis_clk); axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_state", state_dbg, ST_IDLE);
        run_seq("replay", 32'd600, 1, 0, 1'b0, 1'b0);

`ifdef TAP_READBACK_EN
        // Corrupted readback of tap 5 flags err but the sequence completes.
        corrupt = 1;
        run_seq("readback", 32'd31, 1, 0, 1'b1, 1'b0);
        corrupt = 0;
`endif

        repeat (3) @(negedge axis_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
